mem_write_checker: RTL and testbench
====================================

Name: mem_write_checker

Overview:
- Synthesisable, parametrised monitor for the data-memory write port of the top-level processor (memwrite/dataadr/writedata).
- Checks that a programmed list of N_EXP expected (address, data) stores occurs, in order or in any order, with a tolerated address window and a cycle timeout.
- Reports pass/fail/timeout as sticky registered status.
- Used both in simulation benches and as an on-chip self-test flag on FPGA builds.

Parameters:
- ADDR_W, 32, width of dataadr.
- DATA_W, 32, width of writedata.
- N_EXP, 4, number of expected stores (1..16).
- EXP_ADDR, 0, flattened N_EXP*ADDR_W vector; entry i occupies bits [i*ADDR_W +: ADDR_W].
- EXP_DATA, 0, flattened N_EXP*DATA_W vector; same layout as EXP_ADDR.
- ORDERED, 1, 1 = entries must hit in index order; 0 = any order.
- IGN_LO, 0, lower bound of the tolerated-address window (inclusive).
- IGN_HI, 0, upper bound of the tolerated-address window (inclusive). IGN_LO > IGN_HI disables the window.
- TIMEOUT_CYC, 1000, RUN cycles allowed before timeout; 0 disables the timeout.
- CNT_W, 32, width of cycle_cnt.

Ports:
- clk  in  1  rising-edge clock.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  single-cycle pulse that arms or re-arms the checker.
- memwrite  in  1  store strobe from the processor.
- dataadr  in  ADDR_W  store address.
- writedata  in  DATA_W  store data.
- busy  out  1  high in RUN.
- done  out  1  high in PASS, FAIL or TIMEOUT.
- pass  out  1  all expected stores seen.
- fail  out  1  unexpected store seen.
- timeout  out  1  cycle limit reached.
- fail_addr  out  ADDR_W  address of the offending store.
- fail_data  out  DATA_W  data of the offending store.
- match_cnt  out  $clog2(N_EXP+1)  number of entries hit so far.
- cycle_cnt  out  CNT_W  cycles spent in RUN; saturates at all-ones.

Behaviour:
- Reset (reset_n low, asynchronous): state = IDLE; every output, the hit bitmap and next_idx = 0.
- States: IDLE, RUN, PASS, FAIL, TIMEOUT.
- start in any state: go to RUN; clear hit bitmap, next_idx, match_cnt, cycle_cnt, fail_addr and fail_data. memwrite in the start cycle is ignored.
- In RUN, each rising edge with memwrite = 1 samples one store:
  - ORDERED = 1: match only if (dataadr, writedata) equals entry next_idx.
  - ORDERED = 0: match against the lowest-index entry not yet hit with equal (addr, data).
  - Priority: expected match first, then ignore window, then fail.
  - Match: set hit[i], increment match_cnt, increment next_idx when ORDERED = 1.
  - Store in the ignore window (IGN_LO <= dataadr <= IGN_HI) that does not match: no effect.
  - Any other store, including a repeat of an already-hit entry outside the window: go to FAIL and capture fail_addr/fail_data.
- match_cnt reaching N_EXP: go to PASS.
- cycle_cnt increments on every RUN cycle. When TIMEOUT_CYC != 0 and cycle_cnt == TIMEOUT_CYC-1 with no completing match in that cycle: go to TIMEOUT.
- Simultaneous events in one cycle: the final match beats the timeout (PASS). A fail store beats the timeout (FAIL).
- All status outputs are registered and assert on the edge after the sampling edge (latency 1).
- PASS, FAIL and TIMEOUT are sticky; memwrite is ignored in them and only start or reset leaves them.
- start while in RUN restarts the check cleanly.
- Reset asserted mid-RUN: immediate return to IDLE with all outputs 0.
- pass, fail and timeout are one-hot; done = pass | fail | timeout.

Decomposition:
- Shared header mwc_defs.vh holds the state encodings (MWC_IDLE=0, MWC_RUN=1, MWC_PASS=2, MWC_FAIL=3, MWC_TIMEOUT=4) and a CLOG2 macro.
- One sub-module, mwc_match_table: combinational. Inputs are dataadr, writedata, the hit bitmap and next_idx; outputs are match, match_idx and in_ignore.
- The FSM, counters and capture registers stay in mem_write_checker.

Test Plan:
- N_EXP=1, EXP=(84,7), IGN=80..80; start, stores (80,5), (84,7) -> pass=1 one cycle after the second store, match_cnt=1, fail=0.
- Same configuration; store (88,7) -> fail=1, fail_addr=88, fail_data=7; a later store (84,7) leaves pass=0.
- N_EXP=2, EXP={(84,7),(88,9)}, ORDERED=1; stores (88,9) then (84,7) -> fail at (88,9). With ORDERED=0 the same sequence -> pass, match_cnt=2.
- TIMEOUT_CYC=20, no stores -> timeout=1 with cycle_cnt=19 at entry. Final match on cycle 19 -> pass, not timeout.
- Assert reset_n low mid-RUN with match_cnt=1 -> all outputs 0 immediately. Then start and a full sequence -> pass.
- From FAIL, pulse start -> busy=1, fail=0, fail_addr=0, and a subsequent correct sequence -> pass.

Source files
------------

// File: rtl/mem_write_checker_pkg.sv
// Shared definitions for the data-memory write checker.
//   mwc_state_e : checker FSM state encoding
//   mwc_clog2   : ceil(log2(n)), usable in constant expressions
package mem_write_checker_pkg;

    typedef enum logic [2:0] {
        StIdle    = 3'd0,
        StRun     = 3'd1,
        StPass    = 3'd2,
        StFail    = 3'd3,
        StTimeout = 3'd4
    } mwc_state_e;

    function automatic int unsigned mwc_clog2(input int unsigned n);
        int unsigned w;
        w = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(n)) begin
                w = i + 1;
            end
        end
        return w;
    endfunction

    // Width of an entry index; never zero so one-entry tables still get a port.
    function automatic int unsigned mwc_idx_w(input int unsigned n);
        return (n > 1) ? mwc_clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mem_write_checker_match_table.sv
// Combinational lookup of one store against the expected-store table.
// Ports:
//   dataadr, writedata : store being sampled
//   hit                : entries already matched (used when unordered)
//   next_idx           : entry that must match next (used when ordered)
//   match, match_idx   : store matches an eligible entry, and which one
//   in_ignore          : store address lies in the tolerated window
module mem_write_checker_match_table #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned N_EXP  = 4,
    parameter int unsigned IDX_W  = 2,
    parameter logic [N_EXP*ADDR_W-1:0] EXP_ADDR = '0,
    parameter logic [N_EXP*DATA_W-1:0] EXP_DATA = '0,
    parameter bit ORDERED = 1'b1,
    parameter logic [ADDR_W-1:0] IGN_LO = '0,
    parameter logic [ADDR_W-1:0] IGN_HI = '0
) (
    input  logic [ADDR_W-1:0] dataadr,
    input  logic [DATA_W-1:0] writedata,
    input  logic [N_EXP-1:0]  hit,
    input  logic [IDX_W-1:0]  next_idx,
    output logic              match,
    output logic [IDX_W-1:0]  match_idx,
    output logic              in_ignore
);

    localparam bit IgnEn = (IGN_LO <= IGN_HI);
    localparam logic [ADDR_W-1:0] IgnSpan = IGN_HI - IGN_LO;

    // Only one of hit/next_idx is consulted depending on ORDERED.
    logic unused_inputs;
    assign unused_inputs = ^{hit, next_idx};

    // Offset form avoids a constant compare when IGN_LO is zero.
    assign in_ignore = IgnEn && ((dataadr - IGN_LO) <= IgnSpan);

    always_comb begin
        match     = 1'b0;
        match_idx = '0;
        if (ORDERED) begin
            for (int i = 0; i < int'(N_EXP); i++) begin
                if (next_idx == IDX_W'(i) &&
                    EXP_ADDR[i*ADDR_W +: ADDR_W] == dataadr &&
                    EXP_DATA[i*DATA_W +: DATA_W] == writedata) begin
                    match     = 1'b1;
                    match_idx = IDX_W'(i);
                end
            end
        end else begin
            // Scan downwards so the lowest eligible index is the last one written.
            for (int i = int'(N_EXP) - 1; i >= 0; i--) begin
                if (!hit[i] &&
                    EXP_ADDR[i*ADDR_W +: ADDR_W] == dataadr &&
                    EXP_DATA[i*DATA_W +: DATA_W] == writedata) begin
                    match     = 1'b1;
                    match_idx = IDX_W'(i);
                end
            end
        end
    end

endmodule

// File: rtl/mem_write_checker.sv
// Monitor for the processor data-memory write port. After start it expects
// N_EXP programmed stores (ordered or any order), tolerates stores in an
// address window, and reports a sticky pass / fail / timeout status.
// Ports:
//   clk, reset_n        : clock, asynchronous active-low reset
//   start               : arm / re-arm pulse
//   memwrite, dataadr,
//   writedata           : observed store port
//   busy, done          : checking in progress / finished
//   pass, fail, timeout : one-hot final status
//   fail_addr/fail_data : offending store
//   match_cnt           : entries hit so far
//   cycle_cnt           : RUN cycles, saturating
module mem_write_checker
    import mem_write_checker_pkg::*;
#(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned N_EXP  = 4,
    parameter logic [N_EXP*ADDR_W-1:0] EXP_ADDR = '0,
    parameter logic [N_EXP*DATA_W-1:0] EXP_DATA = '0,
    parameter bit ORDERED = 1'b1,
    parameter logic [ADDR_W-1:0] IGN_LO = '0,
    parameter logic [ADDR_W-1:0] IGN_HI = '0,
    parameter int unsigned TIMEOUT_CYC = 1000,
    parameter int unsigned CNT_W = 32
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       start,
    input  logic                       memwrite,
    input  logic [ADDR_W-1:0]          dataadr,
    input  logic [DATA_W-1:0]          writedata,
    output logic                       busy,
    output logic                       done,
    output logic                       pass,
    output logic                       fail,
    output logic                       timeout,
    output logic [ADDR_W-1:0]          fail_addr,
    output logic [DATA_W-1:0]          fail_data,
    output logic [$clog2(N_EXP+1)-1:0] match_cnt,
    output logic [CNT_W-1:0]           cycle_cnt
);

    localparam int unsigned MC_W  = $clog2(N_EXP + 1);
    localparam int unsigned IDX_W = mwc_idx_w(N_EXP);
    localparam bit TmoEn = (TIMEOUT_CYC != 0);
    localparam logic [CNT_W-1:0] TmoLast = CNT_W'(TIMEOUT_CYC - 1);
    localparam logic [MC_W-1:0] LastCnt = MC_W'(N_EXP - 1);

    mwc_state_e         state_q, state_d;
    logic [N_EXP-1:0]   hit_q, hit_d;
    logic [IDX_W-1:0]   next_idx_q, next_idx_d;
    logic [MC_W-1:0]    match_cnt_q, match_cnt_d;
    logic [CNT_W-1:0]   cycle_cnt_q, cycle_cnt_d;
    logic [ADDR_W-1:0]  fail_addr_q, fail_addr_d;
    logic [DATA_W-1:0]  fail_data_q, fail_data_d;

    logic               match;
    logic [IDX_W-1:0]   match_idx;
    logic               in_ignore;

    mem_write_checker_match_table #(
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W),
        .N_EXP    (N_EXP),
        .IDX_W    (IDX_W),
        .EXP_ADDR (EXP_ADDR),
        .EXP_DATA (EXP_DATA),
        .ORDERED  (ORDERED),
        .IGN_LO   (IGN_LO),
        .IGN_HI   (IGN_HI)
    ) u_match_table (
        .dataadr   (dataadr),
        .writedata (writedata),
        .hit       (hit_q),
        .next_idx  (next_idx_q),
        .match     (match),
        .match_idx (match_idx),
        .in_ignore (in_ignore)
    );

    always_comb begin
        state_d     = state_q;
        hit_d       = hit_q;
        next_idx_d  = next_idx_q;
        match_cnt_d = match_cnt_q;
        cycle_cnt_d = cycle_cnt_q;
        fail_addr_d = fail_addr_q;
        fail_data_d = fail_data_q;

        if (start) begin
            // memwrite in the arming cycle is deliberately ignored.
            state_d     = StRun;
            hit_d       = '0;
            next_idx_d  = '0;
            match_cnt_d = '0;
            cycle_cnt_d = '0;
            fail_addr_d = '0;
            fail_data_d = '0;
        end else if (state_q == StRun) begin
            if (!(&cycle_cnt_q)) begin
                cycle_cnt_d = cycle_cnt_q + 1'b1;
            end
            if (memwrite && match) begin
                hit_d       = hit_q | (N_EXP'(1) << match_idx);
                match_cnt_d = match_cnt_q + 1'b1;
                if (ORDERED) begin
                    next_idx_d = next_idx_q + 1'b1;
                end
                if (match_cnt_q == LastCnt) begin
                    state_d = StPass;
                end
            end else if (memwrite && !in_ignore) begin
                state_d     = StFail;
                fail_addr_d = dataadr;
                fail_data_d = writedata;
            end
            // Final match and fail stores both win over an expiring budget;
            // the count freezes at the last allowed value on timeout.
            if (TmoEn && state_d == StRun && cycle_cnt_q == TmoLast) begin
                state_d     = StTimeout;
                cycle_cnt_d = cycle_cnt_q;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= StIdle;
            hit_q       <= '0;
            next_idx_q  <= '0;
            match_cnt_q <= '0;
            cycle_cnt_q <= '0;
            fail_addr_q <= '0;
            fail_data_q <= '0;
        end else begin
            state_q     <= state_d;
            hit_q       <= hit_d;
            next_idx_q  <= next_idx_d;
            match_cnt_q <= match_cnt_d;
            cycle_cnt_q <= cycle_cnt_d;
            fail_addr_q <= fail_addr_d;
            fail_data_q <= fail_data_d;
        end
    end

    assign busy      = (state_q == StRun);
    assign pass      = (state_q == StPass);
    assign fail      = (state_q == StFail);
    assign timeout   = (state_q == StTimeout);
    assign done      = pass | fail | timeout;
    assign fail_addr = fail_addr_q;
    assign fail_data = fail_data_q;
    assign match_cnt = match_cnt_q;
    assign cycle_cnt = cycle_cnt_q;

endmodule

// File: tb/tb_mem_write_checker.sv
// Bench for mem_write_checker: an ordered and an unordered instance share the
// same stimulus; a store-list model predicts both every cycle.
module tb_mem_write_checker;

    localparam int PH_IDLE = 0;
    localparam int PH_RUN  = 1;
    localparam int PH_PASS = 2;
    localparam int PH_FAIL = 3;
    localparam int PH_TMO  = 4;

    localparam logic [63:0] EXP_A = {32'd88, 32'd84};
    localparam logic [63:0] EXP_D = {32'd9, 32'd7};

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        memwrite;
    logic [31:0] dataadr;
    logic [31:0] writedata;

    logic        busy      [2];
    logic        done      [2];
    logic        pass      [2];
    logic        fail      [2];
    logic        timeout   [2];
    logic [31:0] fail_addr [2];
    logic [31:0] fail_data [2];
    logic [1:0]  match_cnt [2];
    logic [31:0] cycle_cnt [2];

    int n_checks = 0;
    int n_fail   = 0;

    // Model state, index 0 = ordered instance, 1 = unordered instance.
    int          m_phase [2];
    bit   [1:0]  m_hit   [2];
    int          m_cnt   [2];
    int          m_cyc   [2];
    logic [31:0] m_fa    [2];
    logic [31:0] m_fd    [2];
    logic [31:0] exp_a   [2] = '{32'd84, 32'd88};
    logic [31:0] exp_d   [2] = '{32'd7, 32'd9};

    mem_write_checker #(
        .ADDR_W(32), .DATA_W(32), .N_EXP(2), .EXP_ADDR(EXP_A), .EXP_DATA(EXP_D),
        .ORDERED(1'b1), .IGN_LO(32'd80), .IGN_HI(32'd80), .TIMEOUT_CYC(20), .CNT_W(32)
    ) u_ord (
        .clk(clk), .reset_n(rst_n), .start(start), .memwrite(memwrite),
        .dataadr(dataadr), .writedata(writedata), .busy(busy[0]), .done(done[0]),
        .pass(pass[0]), .fail(fail[0]), .timeout(timeout[0]), .fail_addr(fail_addr[0]),
        .fail_data(fail_data[0]), .match_cnt(match_cnt[0]), .cycle_cnt(cycle_cnt[0])
    );

    mem_write_checker #(
        .ADDR_W(32), .DATA_W(32), .N_EXP(2), .EXP_ADDR(EXP_A), .EXP_DATA(EXP_D),
        .ORDERED(1'b0), .IGN_LO(32'd80), .IGN_HI(32'd80), .TIMEOUT_CYC(20), .CNT_W(32)
    ) u_any (
        .clk(clk), .reset_n(rst_n), .start(start), .memwrite(memwrite),
        .dataadr(dataadr), .writedata(writedata), .busy(busy[1]), .done(done[1]),
        .pass(pass[1]), .fail(fail[1]), .timeout(timeout[1]), .fail_addr(fail_addr[1]),
        .fail_data(fail_data[1]), .match_cnt(match_cnt[1]), .cycle_cnt(cycle_cnt[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s actual=%0d required=%0d at %0t", nm, act, expv, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_phase[k] = PH_IDLE;
            m_hit[k]   = 2'b00;
            m_cnt[k]   = 0;
            m_cyc[k]   = 0;
            m_fa[k]    = '0;
            m_fd[k]    = '0;
        end
    endtask

    // One rising edge of the specification's rules for both instances.
    task automatic model_edge(input bit st, input bit we, input logic [31:0] a,
                              input logic [31:0] d);
        int found;
        for (int k = 0; k < 2; k++) begin
            if (st) begin
                m_phase[k] = PH_RUN;
                m_hit[k]   = 2'b00;
                m_cnt[k]   = 0;
                m_cyc[k]   = 0;
                m_fa[k]    = '0;
                m_fd[k]    = '0;
            end else if (m_phase[k] == PH_RUN) begin
                found = -1;
                if (we) begin
                    for (int i = 0; i < 2; i++) begin
                        // Ordered: only the entry numbered by the hits so far is eligible.
                        if (found < 0 && !m_hit[k][i] && exp_a[i] == a && exp_d[i] == d &&
                            (k == 1 || i == m_cnt[k])) begin
                            found = i;
                        end
                    end
                end
                if (found >= 0) begin
                    m_hit[k][found] = 1'b1;
                    m_cnt[k]++;
                    if (m_cnt[k] == 2) m_phase[k] = PH_PASS;
                end else if (we && a != 32'd80) begin
                    m_phase[k] = PH_FAIL;
                    m_fa[k]    = a;
                    m_fd[k]    = d;
                end
                if (m_phase[k] == PH_RUN && m_cyc[k] == 19) m_phase[k] = PH_TMO;
                else m_cyc[k]++;
            end
        end
    endtask

    task automatic step(input bit st, input bit we, input logic [31:0] a, input logic [31:0] d);
        start     = st;
        memwrite  = we;
        dataadr   = a;
        writedata = d;
        @(posedge clk);
        if (rst_n) model_edge(st, we, a, d);
        #1;
        start    = 1'b0;
        memwrite = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 32'd0, 32'd0);
    endtask

    // Per-cycle comparison against the model, away from the rising edge.
    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("busy%0d", k), 32'(busy[k]), 32'(m_phase[k] == PH_RUN));
            chk($sformatf("pass%0d", k), 32'(pass[k]), 32'(m_phase[k] == PH_PASS));
            chk($sformatf("fail%0d", k), 32'(fail[k]), 32'(m_phase[k] == PH_FAIL));
            chk($sformatf("timeout%0d", k), 32'(timeout[k]), 32'(m_phase[k] == PH_TMO));
            chk($sformatf("done%0d", k), 32'(done[k]), 32'(m_phase[k] >= PH_PASS));
            chk($sformatf("fail_addr%0d", k), fail_addr[k], m_fa[k]);
            chk($sformatf("fail_data%0d", k), fail_data[k], m_fd[k]);
            chk($sformatf("match_cnt%0d", k), 32'(match_cnt[k]), 32'(m_cnt[k]));
            chk($sformatf("cycle_cnt%0d", k), cycle_cnt[k], 32'(m_cyc[k]));
        end
    end

    initial begin
        rst_n = 1'b0; start = 1'b0; memwrite = 1'b0; dataadr = '0; writedata = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", 32'(busy[0]), 0);
        chk("rst_done", 32'(done[0]), 0);
        chk("rst_cycle", cycle_cnt[1], 0);
        rst_n = 1'b1;
        idle(2);

        // Store in the arming cycle is ignored; in-order pass with ignored store.
        step(1, 1, 32'd92, 32'd7);
        chk("arm_busy", 32'(busy[0]), 1);
        chk("arm_nofail", 32'(fail[1]), 0);
        step(0, 1, 32'd84, 32'd7);
        step(0, 1, 32'd80, 32'd5);
        chk("a_cnt1", 32'(match_cnt[0]), 1);
        step(0, 1, 32'd88, 32'd9);
        chk("a_pass0", 32'(pass[0]), 1);
        chk("a_pass1", 32'(pass[1]), 1);
        chk("a_cnt2", 32'(match_cnt[0]), 2);
        step(0, 1, 32'd92, 32'd7);
        chk("a_sticky", 32'(pass[0]), 1);

        // Reversed order: ordered fails, unordered passes.
        step(1, 0, 0, 0);
        step(0, 1, 32'd88, 32'd9);
        chk("b_fail0", 32'(fail[0]), 1);
        chk("b_faddr0", fail_addr[0], 88);
        chk("b_fdata0", fail_data[0], 9);
        chk("b_cnt1", 32'(match_cnt[1]), 1);
        step(0, 1, 32'd84, 32'd7);
        chk("b_pass1", 32'(pass[1]), 1);
        chk("b_nopass0", 32'(pass[0]), 0);

        // Restart out of FAIL clears capture, then a correct sequence passes.
        step(1, 0, 0, 0);
        chk("c_busy", 32'(busy[0]), 1);
        chk("c_clrfail", 32'(fail[0]), 0);
        chk("c_clraddr", fail_addr[0], 0);
        step(0, 1, 32'd84, 32'd7);
        step(0, 1, 32'd88, 32'd9);
        chk("c_pass0", 32'(pass[0]), 1);

        // Unexpected store, later correct stores cannot rescue it.
        step(1, 0, 0, 0);
        step(0, 1, 32'd92, 32'd7);
        chk("d_faddr1", fail_addr[1], 92);
        chk("d_fdata1", fail_data[1], 7);
        step(0, 1, 32'd84, 32'd7);
        step(0, 1, 32'd88, 32'd9);
        chk("d_nopass", 32'(pass[0]), 0);
        chk("d_cnt0", 32'(match_cnt[0]), 0);

        // Repeat of a hit entry fails in both modes.
        step(1, 0, 0, 0);
        step(0, 1, 32'd84, 32'd7);
        step(0, 1, 32'd84, 32'd7);
        chk("e_fail1", 32'(fail[1]), 1);
        chk("e_faddr1", fail_addr[1], 84);

        // Timeout with no stores.
        step(1, 0, 0, 0);
        idle(19);
        chk("f_busy", 32'(busy[0]), 1);
        chk("f_cyc19", cycle_cnt[0], 19);
        idle(1);
        chk("f_tmo0", 32'(timeout[0]), 1);
        chk("f_tmo1", 32'(timeout[1]), 1);
        chk("f_cyc", cycle_cnt[0], 19);

        // Final match on the last allowed cycle wins over timeout.
        step(1, 0, 0, 0);
        step(0, 1, 32'd84, 32'd7);
        idle(18);
        step(0, 1, 32'd88, 32'd9);
        chk("g_pass", 32'(pass[0]), 1);
        chk("g_notmo", 32'(timeout[0]), 0);
        chk("g_cyc", cycle_cnt[0], 20);

        // Fail store on the last allowed cycle wins over timeout.
        step(1, 0, 0, 0);
        idle(19);
        step(0, 1, 32'd100, 32'd1);
        chk("h_fail", 32'(fail[0]), 1);
        chk("h_notmo", 32'(timeout[1]), 0);

        // Start while running restarts from entry 0.
        step(1, 0, 0, 0);
        step(0, 1, 32'd84, 32'd7);
        step(1, 0, 0, 0);
        step(0, 1, 32'd88, 32'd9);
        chk("i_fail0", 32'(fail[0]), 1);
        chk("i_cnt1", 32'(match_cnt[1]), 1);

        // Asynchronous reset mid-RUN.
        step(1, 0, 0, 0);
        step(0, 1, 32'd84, 32'd7);
        chk("j_cnt", 32'(match_cnt[0]), 1);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        chk("j_busy", 32'(busy[0]), 0);
        chk("j_cnt0", 32'(match_cnt[0]), 0);
        chk("j_cyc0", cycle_cnt[1], 0);
        #3 rst_n = 1'b1;
        idle(1);
        step(1, 0, 0, 0);
        step(0, 1, 32'd84, 32'd7);
        step(0, 1, 32'd88, 32'd9);
        chk("j_pass0", 32'(pass[0]), 1);
        chk("j_pass1", 32'(pass[1]), 1);

        idle(2);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
